// File: rtl/light_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : light_pkg
//  Purpose  : Shared definitions for the traffic-light conflict monitor:
//             lamp pattern type, the eight legal phase patterns, the all-red
//             and all-dark patterns, fault cause codes and FSM state encoding.
//             Each 12-bit pattern holds fields N,E,S,W (MSB first). Each field
//             is {green,yellow,red}.
//  Revision : 1.0 - initial release
// ============================================================================
package light_pkg;

    typedef logic [11:0] pattern_t;
    typedef logic [2:0]  fault_code_t;
    typedef logic [1:0]  state_t;

    // Legal phase patterns, in normal cycle order
    localparam pattern_t c_PAT_4111 = 12'o4111;
    localparam pattern_t c_PAT_2112 = 12'o2112;
    localparam pattern_t c_PAT_1114 = 12'o1114;
    localparam pattern_t c_PAT_1212 = 12'o1212;
    localparam pattern_t c_PAT_1411 = 12'o1411;
    localparam pattern_t c_PAT_1221 = 12'o1221;
    localparam pattern_t c_PAT_1121 = 12'o1121;
    localparam pattern_t c_PAT_2121 = 12'o2121;

    localparam pattern_t c_ALL_RED  = 12'o1111;
    localparam pattern_t c_ALL_OFF  = 12'o0000;

    // Fault causes; a lower code wins when several arise together
    localparam fault_code_t c_FC_NONE         = 3'd0;
    localparam fault_code_t c_FC_ILLEGAL_LAMP = 3'd1;
    localparam fault_code_t c_FC_MULTI_GREEN  = 3'd2;
    localparam fault_code_t c_FC_GREEN_YELLOW = 3'd3;
    localparam fault_code_t c_FC_BAD_SEQUENCE = 3'd4;
    localparam fault_code_t c_FC_SHORT_PHASE  = 3'd5;
    localparam fault_code_t c_FC_STUCK        = 3'd6;

    localparam state_t c_ST_INIT    = 2'd0;
    localparam state_t c_ST_MONITOR = 2'd1;
    localparam state_t c_ST_FAULT   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/light_conflict_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module   : light_conflict_monitor_if
//  Purpose  : Signal bundle between the upstream controller / lamp drivers and
//             the conflict monitor.
//  Ports    : tick_1s, lightin, clear_fault  -> monitor
//             lamp_out, fault, fault_code    <- monitor
//             master = controller side, slave = monitor side
//  Revision : 1.0 - initial release
// ============================================================================
interface light_conflict_monitor_if;
    import light_pkg::*;

    logic        tick_1s;
    pattern_t    lightin;
    logic        clear_fault;
    pattern_t    lamp_out;
    logic        fault;
    fault_code_t fault_code;

    modport master (
        output tick_1s, lightin, clear_fault,
        input  lamp_out, fault, fault_code
    );

    modport slave (
        input  tick_1s, lightin, clear_fault,
        output lamp_out, fault, fault_code
    );

endinterface
`default_nettype wire

// File: rtl/light_pattern_check.sv
`default_nettype none
// ============================================================================
//  Module   : light_pattern_check
//  Purpose  : Purely combinational pattern checker. Flags static conflicts in
//             the incoming pattern and illegal per-field transitions from the
//             previously accepted pattern.
//  Ports    : i_lightin       incoming pattern
//             i_prev          last accepted pattern
//             o_illegal       some field is not one-hot
//             o_multi_green   more than one field green
//             o_green_yellow  a green and a yellow are lit together
//             o_bad_seq       a field went red->green or green->non-yellow
//  Revision : 1.0 - initial release
// ============================================================================
module light_pattern_check
    import light_pkg::*;
(
    input  pattern_t i_lightin,
    input  pattern_t i_prev,
    output logic     o_illegal,
    output logic     o_multi_green,
    output logic     o_green_yellow,
    output logic     o_bad_seq
);

    logic [2:0] w_cur;
    logic [2:0] w_prv;
    logic [2:0] w_greens;
    logic       w_any_green;
    logic       w_any_yellow;

    always_comb begin
        o_illegal    = 1'b0;
        o_bad_seq    = 1'b0;
        w_greens     = 3'd0;
        w_any_green  = 1'b0;
        w_any_yellow = 1'b0;
        w_cur        = 3'b000;
        w_prv        = 3'b000;
        for (int f = 0; f < 4; f++) begin
            w_cur = i_lightin[f*3 +: 3];
            w_prv = i_prev[f*3 +: 3];
            if (!(w_cur == 3'b100 || w_cur == 3'b010 || w_cur == 3'b001))
                o_illegal = 1'b1;
            w_greens     = w_greens + {2'b00, w_cur[2]};
            w_any_green  = w_any_green  | w_cur[2];
            w_any_yellow = w_any_yellow | w_cur[1];
            // A field may only leave green through yellow, and never jump
            // straight from red to green.
            if (w_prv == 3'b001 && w_cur == 3'b100)
                o_bad_seq = 1'b1;
            if (w_prv == 3'b100 && w_cur != 3'b100 && w_cur != 3'b010)
                o_bad_seq = 1'b1;
        end
        o_multi_green  = (w_greens > 3'd1);
        o_green_yellow = w_any_green & w_any_yellow;
    end

endmodule
`default_nettype wire

// File: rtl/light_conflict_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : light_conflict_monitor
//  Purpose  : Safety monitor between a traffic-light controller and its lamps.
//             Passes legal patterns through with one clock of latency and
//             forces a flashing all-red display on any conflict, illegal
//             transition, too-short phase or stuck phase.
//  Ports    : clk   rising-edge clock
//             rst   synchronous active-high reset
//             bus   light_conflict_monitor_if.slave (tick_1s, lightin,
//                   clear_fault in; lamp_out, fault, fault_code out)
//  Revision : 1.0 - initial release
// ============================================================================
module light_conflict_monitor
    import light_pkg::*;
#(
    parameter int GREEN_MIN  = 50,
    parameter int YELLOW_MIN = 10,
    parameter int MAX_DWELL  = 70
) (
    input  wire                          clk,
    input  wire                          rst,
    light_conflict_monitor_if.slave      bus
);

    localparam logic [7:0] c_GREEN_MIN  = 8'(GREEN_MIN);
    localparam logic [7:0] c_YELLOW_MIN = 8'(YELLOW_MIN);
    localparam logic [7:0] c_MAX_DWELL  = 8'(MAX_DWELL);

    state_t      r_state;
    pattern_t    r_lamp;
    pattern_t    r_prev;
    logic        r_fault;
    fault_code_t r_code;
    logic [7:0]  r_dwell;
    logic        r_flash_on;

    logic        w_illegal;
    logic        w_multi_green;
    logic        w_green_yellow;
    logic        w_bad_seq;
    logic        w_change;
    logic        w_prev_green;
    logic        w_short;
    logic        w_stuck;
    fault_code_t w_code;

    light_pattern_check u_check (
        .i_lightin      (bus.lightin),
        .i_prev         (r_prev),
        .o_illegal      (w_illegal),
        .o_multi_green  (w_multi_green),
        .o_green_yellow (w_green_yellow),
        .o_bad_seq      (w_bad_seq)
    );

    assign w_change     = (bus.lightin != r_prev);
    assign w_prev_green = r_prev[11] | r_prev[8] | r_prev[5] | r_prev[2];
    assign w_short      = w_prev_green ? (r_dwell < c_GREEN_MIN)
                                       : (r_dwell < c_YELLOW_MIN);
    // Dwell is about to reach MAX_DWELL+1; a change on the same cycle
    // resets dwell instead, so it suppresses the watchdog.
    assign w_stuck      = bus.tick_1s & ~w_change & (r_dwell == c_MAX_DWELL);

    // Later assignments overwrite earlier ones, so the lowest code wins.
    always_comb begin
        w_code = c_FC_NONE;
        if (r_state == c_ST_MONITOR) begin
            if (w_stuck)              w_code = c_FC_STUCK;
            if (w_change && w_short)  w_code = c_FC_SHORT_PHASE;
            if (w_change && w_bad_seq) w_code = c_FC_BAD_SEQUENCE;
        end
        if (r_state != c_ST_FAULT) begin
            if (w_green_yellow) w_code = c_FC_GREEN_YELLOW;
            if (w_multi_green)  w_code = c_FC_MULTI_GREEN;
            if (w_illegal)      w_code = c_FC_ILLEGAL_LAMP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_INIT;
            r_lamp     <= c_ALL_RED;
            r_prev     <= c_ALL_RED;
            r_fault    <= 1'b0;
            r_code     <= c_FC_NONE;
            r_dwell    <= 8'd0;
            r_flash_on <= 1'b1;
        end else begin
            case (r_state)
                c_ST_INIT, c_ST_MONITOR: begin
                    if (w_code != c_FC_NONE) begin
                        r_state    <= c_ST_FAULT;
                        r_fault    <= 1'b1;
                        r_code     <= w_code;
                        r_lamp     <= c_ALL_RED;
                        r_flash_on <= 1'b1;
                    end else begin
                        r_state <= c_ST_MONITOR;
                        r_lamp  <= bus.lightin;
                        r_prev  <= bus.lightin;
                        if (r_state == c_ST_INIT || w_change)
                            r_dwell <= 8'd0;
                        else if (bus.tick_1s && r_dwell != 8'hFF)
                            r_dwell <= r_dwell + 8'd1;
                    end
                end
                c_ST_FAULT: begin
                    if (bus.clear_fault) begin
                        r_state    <= c_ST_INIT;
                        r_fault    <= 1'b0;
                        r_code     <= c_FC_NONE;
                        r_lamp     <= c_ALL_RED;
                        r_flash_on <= 1'b1;
                    end else if (bus.tick_1s) begin
                        r_flash_on <= ~r_flash_on;
                        r_lamp     <= r_flash_on ? c_ALL_OFF : c_ALL_RED;
                    end
                end
                default: r_state <= c_ST_INIT;
            endcase
        end
    end

    assign bus.lamp_out   = r_lamp;
    assign bus.fault      = r_fault;
    assign bus.fault_code = r_code;

endmodule
`default_nettype wire

// File: tb/tb_light_conflict_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_light_conflict_monitor
//  Purpose  : Self-checking bench for light_conflict_monitor. Inputs are
//             driven on the falling edge; the expected outputs for that cycle
//             are queued and compared just after the following rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_light_conflict_monitor;
    import light_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    light_conflict_monitor_if bus();

    light_conflict_monitor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        pattern_t    lamp;
        logic        fault;
        fault_code_t code;
    } exp_t;

    typedef struct {
        string       name;
        pattern_t    p0;
        int          hold;
        pattern_t    p1;
        fault_code_t code;
    } vec_t;

    exp_t  sb_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    string cur_name = "init";

    task automatic check_out();
        exp_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty", cur_name);
            return;
        end
        e = sb_q.pop_front();
        if (bus.lamp_out !== e.lamp || bus.fault !== e.fault ||
            bus.fault_code !== e.code) begin
            n_bad++;
            $display("FAIL %s: got lamp=%o fault=%b code=%0d, want lamp=%o fault=%b code=%0d",
                     e.name, bus.lamp_out, bus.fault, bus.fault_code,
                     e.lamp, e.fault, e.code);
        end
    endtask

    task automatic step(input pattern_t p, input logic tk, input logic clr,
                        input logic rs, input pattern_t e_lamp,
                        input logic e_fault, input fault_code_t e_code);
        @(negedge clk);
        bus.lightin     = p;
        bus.tick_1s     = tk;
        bus.clear_fault = clr;
        rst             = rs;
        sb_q.push_back('{cur_name, e_lamp, e_fault, e_code});
        @(posedge clk);
        #1;
        check_out();
    endtask

    // Reset, then the INIT cycle accepts a legal pattern p
    task automatic do_reset(input pattern_t p);
        step(p, 1'b0, 1'b0, 1'b1, c_ALL_RED, 1'b0, c_FC_NONE);
        step(p, 1'b0, 1'b0, 1'b0, p, 1'b0, c_FC_NONE);
    endtask

    task automatic hold(input pattern_t p, input int n);
        for (int i = 0; i < n; i++) begin
            step(p, 1'b1, 1'b0, 1'b0, p, 1'b0, c_FC_NONE);
            step(p, 1'b0, 1'b0, 1'b0, p, 1'b0, c_FC_NONE);
        end
    endtask

    // Flashing in FAULT: first tick dark, next tick red; lightin is ignored
    task automatic flash(input fault_code_t code);
        step(12'o7777, 1'b1, 1'b0, 1'b0, c_ALL_OFF, 1'b1, code);
        step(12'o4141, 1'b0, 1'b0, 1'b0, c_ALL_OFF, 1'b1, code);
        step(12'o7777, 1'b1, 1'b0, 1'b0, c_ALL_RED, 1'b1, code);
        step(12'o0000, 1'b0, 1'b0, 1'b0, c_ALL_RED, 1'b1, code);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t     vecs[8];
        pattern_t seq[8];
        int       dur[8];

        vecs[0] = '{"green_to_red",     c_PAT_4111, 50, c_PAT_1114, c_FC_BAD_SEQUENCE};
        vecs[1] = '{"short_green",      c_PAT_4111, 30, c_PAT_2112, c_FC_SHORT_PHASE};
        vecs[2] = '{"short_yellow",     c_PAT_2112,  9, c_PAT_1114, c_FC_SHORT_PHASE};
        vecs[3] = '{"multi_green",      c_PAT_4111,  5, 12'o4141,   c_FC_MULTI_GREEN};
        vecs[4] = '{"illegal_lamp",     c_PAT_4111,  5, 12'o4311,   c_FC_ILLEGAL_LAMP};
        vecs[5] = '{"green_yellow",     c_PAT_4111,  5, 12'o4121,   c_FC_GREEN_YELLOW};
        vecs[6] = '{"legal_green_min",  c_PAT_4111, 50, c_PAT_2112, c_FC_NONE};
        vecs[7] = '{"legal_yellow_min", c_PAT_2112, 10, c_PAT_1114, c_FC_NONE};

        seq = '{c_PAT_4111, c_PAT_2112, c_PAT_1114, c_PAT_1212,
                c_PAT_1411, c_PAT_1221, c_PAT_1121, c_PAT_2121};
        dur = '{50, 10, 50, 10, 50, 10, 50, 10};

        bus.lightin     = c_ALL_RED;
        bus.tick_1s     = 1'b0;
        bus.clear_fault = 1'b0;

        // Table-driven single-transition cases
        foreach (vecs[i]) begin
            cur_name = vecs[i].name;
            do_reset(vecs[i].p0);
            hold(vecs[i].p0, vecs[i].hold);
            if (vecs[i].code == c_FC_NONE) begin
                step(vecs[i].p1, 1'b0, 1'b0, 1'b0, vecs[i].p1, 1'b0, c_FC_NONE);
            end else begin
                step(vecs[i].p1, 1'b0, 1'b0, 1'b0, c_ALL_RED, 1'b1, vecs[i].code);
                flash(vecs[i].code);
            end
        end

        // Two full normal cycles; lamp_out follows lightin one clock later
        cur_name = "normal_run";
        do_reset(c_PAT_4111);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 8; k++) begin
                step(seq[k], 1'b0, 1'b0, 1'b0, seq[k], 1'b0, c_FC_NONE);
                hold(seq[k], dur[k]);
            end
        end

        // clear_fault has no effect outside FAULT
        cur_name = "clear_in_monitor";
        step(c_PAT_4111, 1'b1, 1'b1, 1'b0, c_PAT_4111, 1'b0, c_FC_NONE);

        // rst wins over a change cycle
        cur_name = "rst_on_change";
        step(c_PAT_2112, 1'b0, 1'b0, 1'b1, c_ALL_RED, 1'b0, c_FC_NONE);

        // Static fault caught in INIT
        cur_name = "init_multi_green";
        step(12'o4141, 1'b0, 1'b0, 1'b1, c_ALL_RED, 1'b0, c_FC_NONE);
        step(12'o4141, 1'b0, 1'b0, 1'b0, c_ALL_RED, 1'b1, c_FC_MULTI_GREEN);
        flash(c_FC_MULTI_GREEN);

        // rst in the dark phase of FAULT
        cur_name = "rst_mid_fault";
        step(12'o4141, 1'b1, 1'b0, 1'b0, c_ALL_OFF, 1'b1, c_FC_MULTI_GREEN);
        step(12'o4141, 1'b0, 1'b0, 1'b1, c_ALL_RED, 1'b0, c_FC_NONE);

        // Clearing into a still-bad pattern faults again
        cur_name = "clear_into_bad";
        step(12'o4141, 1'b0, 1'b0, 1'b0, c_ALL_RED, 1'b1, c_FC_MULTI_GREEN);
        step(12'o4141, 1'b0, 1'b1, 1'b0, c_ALL_RED, 1'b0, c_FC_NONE);
        step(12'o4141, 1'b0, 1'b0, 1'b0, c_ALL_RED, 1'b1, c_FC_MULTI_GREEN);

        // Clearing into a legal pattern recovers through INIT
        cur_name = "clear_recover";
        step(c_PAT_4111, 1'b0, 1'b1, 1'b0, c_ALL_RED, 1'b0, c_FC_NONE);
        step(c_PAT_4111, 1'b0, 1'b0, 1'b0, c_PAT_4111, 1'b0, c_FC_NONE);
        step(c_PAT_4111, 1'b1, 1'b0, 1'b0, c_PAT_4111, 1'b0, c_FC_NONE);

        // Watchdog: 70 ticks is allowed, the 71st faults
        cur_name = "watchdog_trip";
        do_reset(c_PAT_1114);
        hold(c_PAT_1114, 70);
        step(c_PAT_1114, 1'b1, 1'b0, 1'b0, c_ALL_RED, 1'b1, c_FC_STUCK);
        flash(c_FC_STUCK);

        cur_name = "watchdog_edge_ok";
        do_reset(c_PAT_1114);
        hold(c_PAT_1114, 70);
        step(c_PAT_1212, 1'b0, 1'b0, 1'b0, c_PAT_1212, 1'b0, c_FC_NONE);

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left, want 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
